stream_fifo_arbiter: RTL and testbench
======================================

Name: stream_fifo_arbiter

Overview:
- Round-robin arbiter that shares one deep streaming FIFO input (Q_srl-based StreamingFIFO, 24-bit, depth 8100) among N_IN AXI-Stream producers.
- Grants one producer at a time for a fixed burst of BURST beats.
- Issues a grant only when the FIFO's reported free space can absorb the whole burst, so a burst never stalls on a full FIFO.
- Sits between the producer layer outputs and the FIFO in0_V port; the FIFO's count output feeds back to this block.

Parameters:
- N_IN, 4, number of requesting streams (2..8).
- WIDTH, 24, stream data width.
- DEPTH, 8100, depth of the downstream FIFO.
- CNT_W, 13, width of the FIFO count input; must satisfy 2^CNT_W > DEPTH.
- BURST, 16, beats per grant (1..DEPTH).
- SEL_W, 2, grant index width; must be at least clog2(N_IN).
- TIMEOUT, 255, idle-valid cycles before a burst is aborted (optional feature only).

Ports:
- ap_clk  in  1  single clock; all logic is rising-edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- in_V_TDATA  in  N_IN*WIDTH  producer data; producer i occupies bits [i*WIDTH +: WIDTH].
- in_V_TVALID  in  N_IN  producer valids.
- in_V_TREADY  out  N_IN  producer readies.
- out_V_TDATA  out  WIDTH  to FIFO in0_V_TDATA.
- out_V_TVALID  out  1  to FIFO in0_V_TVALID.
- out_V_TREADY  in  1  from FIFO in0_V_TREADY.
- fifo_count  in  CNT_W  FIFO occupancy (count output of the FIFO).
- grant_idx  out  SEL_W  index of the current or last granted producer.
- busy  out  1  high while in XFER.
- abort_pulse  out  1  one-cycle pulse on timeout abort; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, beat=0, last_ptr=N_IN-1, grant_idx=0.
  - busy=0, abort_pulse=0, all in_V_TREADY=0, out_V_TVALID=0, out_V_TDATA=0.
- Reset mid-burst drops the burst immediately. The partial burst already written stays in the FIFO; this block does not flush it.
- State IDLE:
  - free = DEPTH - fifo_count, computed at CNT_W+1 bits, unsigned.
  - If any in_V_TVALID is set and free >= BURST: select the first valid producer searching last_ptr+1, last_ptr+2, ... modulo N_IN.
  - Register it to sel and grant_idx, clear beat, go to XFER.
  - Otherwise stay in IDLE. No readies are asserted in IDLE.
- State XFER (combinational routing):
  - out_V_TDATA = in_V_TDATA[sel].
  - out_V_TVALID = in_V_TVALID[sel].
  - in_V_TREADY[sel] = out_V_TREADY; all other readies are 0.
  - busy=1.
  - Zero-latency pass-through: no data register in the path.
- Beat counting:
  - Each cycle with out_V_TVALID && out_V_TREADY increments beat.
  - On the handshake with beat==BURST-1: last_ptr<=sel, beat<=0, go to IDLE.
- Minimum one IDLE cycle between bursts, so fifo_count reflects every write accepted before the next space check (FIFO count has one-cycle lag).
- A producer dropping valid mid-burst holds the grant; the arbiter waits indefinitely (unless the optional feature is enabled).
- Fairness: a producer is granted at most once per N_IN grants while others request.
- Boundaries:
  - free == BURST grants; free == BURST-1 does not.
  - fifo_count > DEPTH is treated as free=0 (no grant).
  - last_ptr wraps from N_IN-1 to 0.
- out_V_TDATA is don't-care outside XFER; it is driven to 0 in IDLE.

Optional Feature:
ARB_BURST_TIMEOUT_EN
- Defined:
  - An 8+ bit idle counter increments on each XFER cycle where in_V_TVALID[sel]==0, and clears on any valid cycle.
  - On reaching TIMEOUT: abort_pulse=1 for one cycle, last_ptr<=sel, beat<=0, go to IDLE.
  - The partial burst stays in the FIFO.
- Undefined: no counter logic; abort_pulse tied 0; a stalled producer holds the grant forever.

Test Plan:
- Producers 0 and 2 valid continuously, fifo_count=0, out_V_TREADY=1:
  - Grants alternate 0,2,0,2.
  - Each burst is exactly 16 beats with one idle cycle between.
  - out_V_TDATA matches the granted producer's data.
- fifo_count=8085 (free=15), all producers valid: no grant, busy=0. Lower fifo_count to 8084: grant occurs on the next cycle, to producer 0 after reset.
- Mid-burst backpressure: out_V_TREADY low for beats 5-9. beat holds, in_V_TREADY[sel]=0 during the stall, and the burst completes with exactly 16 handshakes.
- Assert ap_rst_n=0 asynchronously at beat 7: all readies and out_V_TVALID fall in the same cycle without a clock edge. After release, the arbiter is in IDLE and the next grant goes to producer 0.
- With ARB_BURST_TIMEOUT_EN and TIMEOUT=10: the granted producer drops valid after 3 beats. abort_pulse fires on the 10th idle cycle, and the next grant goes to the next valid producer.
- All four producers valid: 8 consecutive grants follow the sequence 0,1,2,3,0,1,2,3.

Source files
------------

// File: rtl/stream_fifo_arbiter.sv
// rtl/stream_fifo_arbiter.sv - round-robin burst arbiter feeding one streaming FIFO (optional: ARB_BURST_TIMEOUT_EN)
module stream_fifo_arbiter #(
  parameter int N_IN    = 4,
  parameter int WIDTH   = 24,
  parameter int DEPTH   = 8100,
  parameter int CNT_W   = 13,
  parameter int BURST   = 16,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [N_IN*WIDTH-1:0] in_V_TDATA,
  input  logic [N_IN-1:0]       in_V_TVALID,
  output logic [N_IN-1:0]       in_V_TREADY,
  output logic [WIDTH-1:0]      out_V_TDATA,
  output logic                  out_V_TVALID,
  input  logic                  out_V_TREADY,
  input  logic [CNT_W-1:0]      fifo_count,
  output logic [SEL_W-1:0]      grant_idx,
  output logic                  busy,
  output logic                  abort_pulse
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);
  localparam logic [CNT_W:0]    DEPTH_X   = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W:0]    BURST_X   = (CNT_W + 1)'(BURST);

  state_t            state, state_nx;
  logic [SEL_W-1:0]  sel, sel_nx;
  logic [SEL_W-1:0]  last_ptr, last_ptr_nx;
  logic [BEAT_W-1:0] beat, beat_nx;
  logic [CNT_W:0]    free;
  logic              space_ok;
  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;
  logic [SEL_W-1:0]  cand;
  logic              handshake;
  logic              timeout_hit;
  logic [WIDTH-1:0]  in_data [N_IN];

  // Unpack the flat producer bus so the granted lane can be selected by index.
  for (genvar i = 0; i < N_IN; i++) begin : g_unpack
    assign in_data[i] = in_V_TDATA[i*WIDTH +: WIDTH];
  end

  assign grant_idx = sel;
  assign handshake = out_V_TVALID && out_V_TREADY;

  // Free space in the FIFO; an out-of-range count is treated as completely full.
  always_comb begin
    free = '0;
    if ({1'b0, fifo_count} <= DEPTH_X) begin
      free = DEPTH_X - {1'b0, fifo_count};
    end
    space_ok = (free >= BURST_X);
  end

  // Round-robin search starting just after the last producer served.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= N_IN; k++) begin
      cand = SEL_W'((int'(last_ptr) + k) % N_IN);
      if (!pick_found && in_V_TVALID[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef ARB_BURST_TIMEOUT_EN
  localparam int IDLE_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = (state == XFER) && !in_V_TVALID[sel] && (idle_cnt == IDLE_LAST);

  // Count consecutive cycles the granted producer leaves the bus idle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      idle_cnt <= '0;
    end else if (timeout_hit) begin
      idle_cnt <= '0;
    end else if (state == XFER && !in_V_TVALID[sel]) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state decode plus zero-latency routing of the granted producer.
  always_comb begin
    state_nx     = state;
    sel_nx       = sel;
    last_ptr_nx  = last_ptr;
    beat_nx      = beat;
    busy         = 1'b0;
    abort_pulse  = 1'b0;
    in_V_TREADY  = '0;
    out_V_TVALID = 1'b0;
    out_V_TDATA  = '0;
    case (state)
      IDLE: begin
        if (pick_found && space_ok) begin
          sel_nx   = pick_idx;
          beat_nx  = '0;
          state_nx = XFER;
        end
      end
      XFER: begin
        busy              = 1'b1;
        out_V_TDATA       = in_data[sel];
        out_V_TVALID      = in_V_TVALID[sel];
        in_V_TREADY[sel]  = out_V_TREADY;
        if (handshake) begin
          if (beat == BEAT_LAST) begin
            last_ptr_nx = sel;
            beat_nx     = '0;
            state_nx    = IDLE;
          end else begin
            beat_nx = beat + 1'b1;
          end
        end else if (timeout_hit) begin
          abort_pulse = 1'b1;
          last_ptr_nx = sel;
          beat_nx     = '0;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset drops any burst in progress immediately.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      last_ptr <= SEL_W'(N_IN - 1);
      beat     <= '0;
    end else begin
      state    <= state_nx;
      sel      <= sel_nx;
      last_ptr <= last_ptr_nx;
      beat     <= beat_nx;
    end
  end

endmodule

// File: tb/tb_stream_fifo_arbiter.sv
// tb/tb_stream_fifo_arbiter.sv - directed self-checking bench for stream_fifo_arbiter
module tb_stream_fifo_arbiter;

  localparam int N_IN  = 4;
  localparam int WIDTH = 24;
  localparam int CNT_W = 13;
  localparam int SEL_W = 2;

  logic                  ap_clk;
  logic                  ap_rst_n;
  logic [N_IN*WIDTH-1:0] in_V_TDATA;
  logic [N_IN-1:0]       in_V_TVALID;
  logic [N_IN-1:0]       in_V_TREADY;
  logic [WIDTH-1:0]      out_V_TDATA;
  logic                  out_V_TVALID;
  logic                  out_V_TREADY;
  logic [CNT_W-1:0]      fifo_count;
  logic [SEL_W-1:0]      grant_idx;
  logic                  busy;
  logic                  abort_pulse;

  int checks = 0;
  int errors = 0;

  stream_fifo_arbiter dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .in_V_TDATA   (in_V_TDATA),
    .in_V_TVALID  (in_V_TVALID),
    .in_V_TREADY  (in_V_TREADY),
    .out_V_TDATA  (out_V_TDATA),
    .out_V_TVALID (out_V_TVALID),
    .out_V_TREADY (out_V_TREADY),
    .fifo_count   (fifo_count),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .abort_pulse  (abort_pulse)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  typedef struct {
    int         cnt;
    logic [3:0] valid;
    int         exp_busy;
    int         exp_grant;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [WIDTH-1:0] prod_data(input int i);
    logic [WIDTH-1:0] d;
    d = 24'h5A0000 + 24'h010101 * WIDTH'(i + 1);
    return d;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic do_burst(input int exp_g, input bit stall, output int gap);
    int hs;
    int cyc;
    int st;
    hs = 0;
    cyc = 0;
    st = 0;
    while (!busy && cyc < 20) begin
      @(posedge ap_clk);
      #1;
      cyc++;
    end
    gap = cyc;
    check("grant_seen", int'(busy), 1);
    check("grant_idx", int'(grant_idx), exp_g);
    cyc = 0;
    while (busy && cyc < 200) begin
      if (stall && hs == 5 && st < 5) begin
        out_V_TREADY = 1'b0;
        st++;
      end else begin
        out_V_TREADY = 1'b1;
      end
      #1;
      if (!out_V_TREADY) check("stall_in_ready", int'(in_V_TREADY), 0);
      else               check("in_ready", int'(in_V_TREADY), 1 << exp_g);
      check("out_data", int'(out_V_TDATA), int'(prod_data(exp_g)));
      check("abort_idle", int'(abort_pulse), 0);
      if (out_V_TVALID && out_V_TREADY) hs++;
      @(posedge ap_clk);
      #1;
      cyc++;
    end
    out_V_TREADY = 1'b1;
    check("burst_len", hs, 16);
    if (stall) check("stall_cycles", st, 5);
  endtask

  initial begin
    int gap;
    int hs;
    int cyc;

    vecs[0] = '{cnt: 0,    valid: 4'b0001, exp_busy: 1, exp_grant: 0};
    vecs[1] = '{cnt: 0,    valid: 4'b0100, exp_busy: 1, exp_grant: 2};
    vecs[2] = '{cnt: 8085, valid: 4'b1111, exp_busy: 0, exp_grant: 0};
    vecs[3] = '{cnt: 8084, valid: 4'b1111, exp_busy: 1, exp_grant: 0};
    vecs[4] = '{cnt: 8100, valid: 4'b1111, exp_busy: 0, exp_grant: 0};
    vecs[5] = '{cnt: 8191, valid: 4'b1111, exp_busy: 0, exp_grant: 0};
    vecs[6] = '{cnt: 0,    valid: 4'b0000, exp_busy: 0, exp_grant: 0};
    vecs[7] = '{cnt: 0,    valid: 4'b1000, exp_busy: 1, exp_grant: 3};
    vecs[8] = '{cnt: 0,    valid: 4'b1010, exp_busy: 1, exp_grant: 1};
    vecs[9] = '{cnt: 7000, valid: 4'b0110, exp_busy: 1, exp_grant: 1};

    for (int i = 0; i < N_IN; i++) in_V_TDATA[i*WIDTH +: WIDTH] = prod_data(i);
    in_V_TVALID  = '0;
    out_V_TREADY = 1'b1;
    fifo_count   = '0;
    ap_rst_n     = 1'b0;

    // reset state
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_V_TREADY), 0);
    check("rst_out_valid", int'(out_V_TVALID), 0);
    check("rst_out_data", int'(out_V_TDATA), 0);
    check("rst_grant", int'(grant_idx), 0);
    check("rst_abort", int'(abort_pulse), 0);

    // single IDLE decision per vector, each from reset
    for (int v = 0; v < 10; v++) begin
      @(negedge ap_clk);
      ap_rst_n     = 1'b0;
      fifo_count   = CNT_W'(vecs[v].cnt);
      in_V_TVALID  = vecs[v].valid;
      out_V_TREADY = 1'b1;
      #1;
      check("vec_rst_ready", int'(in_V_TREADY), 0);
      check("vec_rst_busy", int'(busy), 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      check("vec_busy", int'(busy), vecs[v].exp_busy);
      check("vec_grant", int'(grant_idx), vecs[v].exp_grant);
      check("vec_in_ready", int'(in_V_TREADY),
            vecs[v].exp_busy ? (1 << vecs[v].exp_grant) : 0);
      check("vec_out_valid", int'(out_V_TVALID), vecs[v].exp_busy);
      check("vec_out_data", int'(out_V_TDATA),
            vecs[v].exp_busy ? int'(prod_data(vecs[v].exp_grant)) : 0);
    end

    // producers 0 and 2 alternate, one idle cycle between bursts
    fifo_count  = '0;
    in_V_TVALID = 4'b0101;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      do_burst((k % 2) * 2, 1'b0, gap);
      check("burst_gap", gap, 1);
    end

    // space threshold: free 15 blocks, free 16 grants next cycle
    fifo_count  = CNT_W'(8085);
    in_V_TVALID = 4'b1111;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge ap_clk);
      #1;
      check("thr_no_grant", int'(busy), 0);
    end
    fifo_count = CNT_W'(8084);
    @(posedge ap_clk);
    #1;
    check("thr_grant", int'(busy), 1);
    check("thr_grant_idx", int'(grant_idx), 0);
    do_burst(0, 1'b0, gap);

    // backpressure for five cycles starting at beat 5
    do_burst(1, 1'b1, gap);
    check("bp_gap", gap, 1);

    // asynchronous reset at beat 7 of the burst to producer 2
    cyc = 0;
    while (!busy && cyc < 20) begin
      @(posedge ap_clk);
      #1;
      cyc++;
    end
    check("ar_grant", int'(grant_idx), 2);
    hs = 0;
    cyc = 0;
    while (hs < 7 && cyc < 50) begin
      if (out_V_TVALID && out_V_TREADY) hs++;
      @(posedge ap_clk);
      #1;
      cyc++;
    end
    check("ar_beats", hs, 7);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check("ar_in_ready", int'(in_V_TREADY), 0);
    check("ar_out_valid", int'(out_V_TVALID), 0);
    check("ar_busy", int'(busy), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    do_burst(0, 1'b0, gap);

    // all four requesting: strict rotation
    fifo_count = '0;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      do_burst(k % 4, 1'b0, gap);
      check("rr_gap", gap, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
